// File: rtl/block_sched_pkg.sv
// Shared types and constants for the message-level block-checker scheduler.
// The FLUSH state value is reserved even when BLOCK_SCHED_FLUSH_EN is not defined.
package block_sched_pkg;

  localparam int NREQ_DEF  = 2;
  localparam int LEN_W_DEF = 8;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CLEAR  = ST_CLEAR,
    S_STREAM = ST_STREAM,
    S_FLUSH  = ST_FLUSH,
    S_SETTLE = ST_SETTLE,
    S_RESULT = ST_RESULT
  } state_e;

endpackage

// File: rtl/block_sched_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Zero latency; no backpressure, the caller decides when to act on the pick.
module block_sched_rr #(
  parameter  int NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  grant_o,
  output logic            any_o
);

  int             sum;
  logic           found;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    any_o   = |req_i;
    found   = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr_i) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      cand = sum[IDW-1:0];
      if (!found && req_i[cand]) begin
        grant_o = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_sched.sv
// Grants one shared begin/end checker to a requester per message, clears it first, reports one record per message.
// Unstalled L-byte latency L+4 cycles to done_valid (L+5 with BLOCK_SCHED_FLUSH_EN); requester stalls add cycles 1:1.
module block_sched
  import block_sched_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int LEN_W = LEN_W_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                chk_reset,
  output logic                chk_en,
  output logic [7:0]          chk_in,
  input  logic                chk_result,
  output logic                done_valid,
  output logic [IDW-1:0]      done_id,
  output logic                done_result,
  output logic [LEN_W-1:0]    done_len,
  output logic                busy
);

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             chk_en_q, chk_en_d;
  logic [7:0]       chk_in_q, chk_in_d;
  logic             done_valid_q, done_valid_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             done_result_q, done_result_d;
  logic [LEN_W-1:0] done_len_q, done_len_d;

  logic [IDW-1:0]   rr_pick;
  logic             rr_any;
  logic             cur_vld, cur_last, hs;
  logic [7:0]       cur_dat;

  block_sched_rr #(.NREQ(NREQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (rr_pick),
    .any_o   (rr_any)
  );

  always_comb begin
    cur_vld  = 1'b0;
    cur_last = 1'b0;
    cur_dat  = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_q == IDW'(k)) begin
        cur_vld  = req_valid[k];
        cur_last = req_last[k];
        cur_dat  = req_data[8*k +: 8];
      end
    end
  end

  assign hs        = (state_q == ST_STREAM) && cur_vld;
  assign req_ready = (state_q == ST_STREAM) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_q) : '0;
  assign chk_reset = (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    len_d         = len_q;
    chk_en_d      = 1'b0;
    chk_in_d      = chk_in_q;
    done_valid_d  = 1'b0;
    done_id_d     = done_id_q;
    done_result_d = done_result_q;
    done_len_d    = done_len_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          grant_d = rr_pick;
          rr_d    = (rr_pick == IDW'(NREQ-1)) ? '0 : rr_pick + 1'b1;
          len_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_STREAM;
      ST_STREAM: begin
        // A stalled cycle leaves chk_en low so the checker sees only real bytes.
        if (hs) begin
          chk_in_d = cur_dat;
          chk_en_d = 1'b1;
          if (len_q != {LEN_W{1'b1}}) len_d = len_q + 1'b1;
          if (cur_last) begin
`ifdef BLOCK_SCHED_FLUSH_EN
            state_d = ST_FLUSH;
`else
            state_d = ST_SETTLE;
`endif
          end
        end
      end
`ifdef BLOCK_SCHED_FLUSH_EN
      ST_FLUSH: begin
        chk_in_d = SPACE_CHAR;
        chk_en_d = 1'b1;
        state_d  = ST_SETTLE;
      end
`endif
      ST_SETTLE: state_d = ST_RESULT;
      ST_RESULT: begin
        done_valid_d  = 1'b1;
        done_result_d = chk_result;
        done_id_d     = grant_q;
        done_len_d    = len_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      len_q         <= '0;
      chk_en_q      <= 1'b0;
      chk_in_q      <= 8'h00;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      done_result_q <= 1'b0;
      done_len_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      len_q         <= len_d;
      chk_en_q      <= chk_en_d;
      chk_in_q      <= chk_in_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_result_q <= done_result_d;
      done_len_q    <= done_len_d;
    end
  end

  assign chk_en      = chk_en_q;
  assign chk_in      = chk_in_q;
  assign done_valid  = done_valid_q;
  assign done_id     = done_id_q;
  assign done_result = done_result_q;
  assign done_len    = done_len_q;

endmodule

// File: doc/block_sched.md
# block_sched

Message-level scheduler that shares one case-insensitive begin/end block checker between `NREQ` byte-stream requesters. It grants the checker to one requester for a whole message and clears the checker before each message. It forwards bytes under a valid/ready handshake, samples the checker verdict after the last byte and reports one completion record per message. It sits between the text sources and the single shared checker instance. That checker has a synchronous active-high clear and a clock enable.

## Interface
- `NREQ`, 2: number of requesters (2..8)
- `LEN_W`, 8: width of message length counter
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low
- `req_valid` in NREQ: requester i presents a byte
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i]
- `req_last` in NREQ: byte is the last of its message
- `req_ready` out NREQ: byte accepted when valid & ready at a rising edge
- `chk_reset` out 1: synchronous clear to the shared checker
- `chk_en` out 1: checker consumes `chk_in` at this edge
- `chk_in` out 8: byte to the checker
- `chk_result` in 1: checker verdict; 1 means balanced; registered inside the checker
- `done_valid` out 1: one-cycle pulse, completion record valid
- `done_id` out $clog2(NREQ): requester that owned the message
- `done_result` out 1: sampled `chk_result`
- `done_len` out LEN_W: bytes accepted, saturating
- `busy` out 1: state is not IDLE

## Operation
- States: IDLE, CLEAR, STREAM, FLUSH, SETTLE, RESULT.
- IDLE:
  - `req_ready`=0.
  - If any `req_valid`, latch grant = first valid index at or after rr pointer (wrapping) and go to CLEAR.
  - rr pointer <= grant+1, mod NREQ.
- CLEAR: lasts 1 cycle; `chk_reset`=1, `chk_en`=0; then STREAM.
- STREAM:
  - `req_ready[grant]`=1; all others 0.
  - On handshake: `chk_in`<=data, `chk_en`<=1, len<=len+1, saturating at 2^LEN_W-1.
  - Without handshake: `chk_en`<=0, so a requester stall produces no checker activity.
  - Handshake with `req_last`: go to FLUSH if the macro is compiled in, else SETTLE.
- FLUSH: lasts 1 cycle; `chk_in`<=8'h20 and `chk_en`<=1, closing the final word; then SETTLE.
- SETTLE: `chk_en`<=0; then RESULT.
- RESULT:
  - At the edge: `done_result`<=`chk_result`, `done_id`<=grant, `done_len`<=len, `done_valid`<=1.
  - Go to IDLE.
- `done_valid` is deasserted the following cycle.
- `done_*` hold their values until the next record.
- IDLE may grant in the same cycle `done_valid` is high.
- Length-1 messages are legal. Zero-length messages do not exist.
- `req_last` is ignored without a handshake.
- A requester that drops `req_valid` mid-message only stalls; there is no timeout.

## Timing
- All outputs are registered except `req_ready`, `chk_reset` and `busy`, which decode the state.
- Reset values: state IDLE, rr pointer 0, grant 0, len 0; all outputs 0, `chk_in`=8'h00.
- Reset is asynchronous and can occur mid-message. The message is dropped and no `done_valid` is produced. The requester must restart that message from its first byte.
- Unstalled L-byte message, with cycle 0 as the IDLE cycle that sees valid:
  - CLEAR in cycle 1.
  - STREAM in cycles 2..L+1.
  - With macro: FLUSH L+2, SETTLE L+3, RESULT L+4, `done_valid` in L+5.
  - Without macro: SETTLE L+2, RESULT L+3, `done_valid` in L+4.
- Each stall cycle adds 1 cycle.
- Checker contract: consumes `chk_in` at an edge where `chk_en`=1. Its `chk_result` reflects all consumed bytes in the following cycle.

## Configuration
- `BLOCK_SCHED_FLUSH_EN` defined: the FLUSH state exists and a space is injected after every message. A verdict never depends on a trailing delimiter.
- Undefined: no FLUSH state. Requesters must terminate messages with a space themselves. Latency is one cycle less.

## Structure
- Package `block_sched_pkg`:
  - state enum
  - `SPACE_CHAR` = 8'h20
  - default `NREQ`, `LEN_W`
- Sub-module `block_sched_rr`: combinational round-robin pick (request vector plus pointer in, grant index and any-valid out). It is reused by later shared-resource schedulers.

## Test plan
- **Single message, macro on:** req0 sends "begin End" (9 bytes, last on 'd'), no stalls. Required: `done_valid` in cycle 14 with id 0, result 1, len 9; `chk_reset` high only in cycle 1.
- **Contention:** req0 "end" and req1 "Begin eNd" both valid from cycle 0. Required: req0 is served first with result 0 and len 3, then req1 with result 1 and len 9. `req_ready[1]` stays 0 while req0 streams.
- **Stall:** req0 sends "begin end" with `req_valid` low for 3 cycles after "beg". Required: `chk_en`=0 during the stall; result 1; `done_valid` in cycle 17.
- **Macro off:** req0 sends "begin end " (10 bytes). Required: `done_valid` in cycle 14, result 1, len 10; no 8'h20 injected after the last byte.
- **Reset mid-message:** pull `reset` low during req1's STREAM, with both requesters then valid. Required: outputs at reset values immediately, no `done_valid`, next grant to req0.
- **Length saturation:** with `LEN_W`=4, send a 20-byte message. Required: `done_len`=15.
